// File: rtl/vga_scanout_palette_pkg.sv
// Shared types, the reset-time palette and the latency helper for the
// VGA framebuffer scanout stage.
package scanout_pkg;

   localparam int DEFAULT_COLOR_BITS = 6;

   typedef struct packed {
      logic [DEFAULT_COLOR_BITS-1:0] r;
      logic [DEFAULT_COLOR_BITS-1:0] g;
      logic [DEFAULT_COLOR_BITS-1:0] b;
   } rgb_t;

   // Sixteen-colour EGA-style palette loaded into both palette banks on reset
   localparam rgb_t DEFAULT_PALETTE [16] = '{
      18'h00000, 18'h0002A, 18'h00A80, 18'h00AAA,
      18'h2A000, 18'h2A02A, 18'h2A540, 18'h2AAAA,
      18'h15555, 18'h1557F, 18'h15FD5, 18'h15FFF,
      18'h3F555, 18'h3F57F, 18'h3FFD5, 18'h3FFFF
   };

   function automatic int scanout_latency(input int read_delay);
      return read_delay + 2;
   endfunction

endpackage

// File: rtl/vga_scanout_palette_if.sv
// Framebuffer read port: the scanout stage is master, the memory is slave.
interface vga_scanout_palette_if #(
   parameter int ADDR_BITS = 20,
   parameter int DATA_BITS = 4
);

   logic                 read_en;
   logic [ADDR_BITS-1:0] read_addr;
   logic [DATA_BITS-1:0] read_data;

   modport master (
      output read_en,
      output read_addr,
      input  read_data
   );

   modport slave (
      input  read_en,
      input  read_addr,
      output read_data
   );

endinterface

// File: rtl/vga_scanout_palette_addr_gen.sv
// Address generator: tracks the framebuffer row base without a multiplier and
// registers the read strobe/address. Optional macro: SCANOUT_PAL_ROTATE_EN.
module scanout_addr_gen
   import scanout_pkg::*;
#(
   parameter int WIDTH       = 1024,
   parameter int HEIGHT      = 768,
   parameter int SCALE_SHIFT = 0,
   parameter int ADDR_BITS   = 20
) (
   input  logic        clk_pixel,
   input  logic        reset,
   vga_scanout_palette_if.master fb,
   input  logic [11:0] vga_x,
   input  logic [11:0] vga_y,
   input  logic        video_active
`ifdef SCANOUT_PAL_ROTATE_EN
   ,
   output logic        frame_wrap
`endif
);

   localparam int                   FB_W     = WIDTH >> SCALE_SHIFT;
   localparam logic [11:0]          WIDTH_L  = 12'(WIDTH);
   localparam logic [11:0]          HEIGHT_L = 12'(HEIGHT);
   localparam logic [11:0]          Y_MASK   = 12'((1 << SCALE_SHIFT) - 1);
   localparam logic [ADDR_BITS-1:0] FB_W_A   = ADDR_BITS'(FB_W);

   logic [ADDR_BITS-1:0] row_base;
   logic [ADDR_BITS-1:0] row_base_next;
   logic [11:0]          y_q;
   logic                 y_changed;
   logic                 in_range;

   // A new framebuffer row starts every 2^SCALE_SHIFT screen lines; with no
   // scaling the mask is zero so every line advances the base.
   always_comb begin
      y_changed     = (vga_y != y_q);
      row_base_next = row_base;
      if (y_changed) begin
         if (vga_y == 12'd0) begin
            row_base_next = '0;
         end else if ((vga_y & Y_MASK) == 12'd0) begin
            row_base_next = row_base + FB_W_A;
         end
      end
      in_range = video_active && (vga_x < WIDTH_L) && (vga_y < HEIGHT_L);
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         row_base     <= '0;
         y_q          <= '0;
         fb.read_en   <= 1'b0;
         fb.read_addr <= '0;
      end else begin
         y_q        <= vga_y;
         row_base   <= row_base_next;
         fb.read_en <= in_range;
         if (in_range) begin
            fb.read_addr <= row_base_next + ADDR_BITS'(vga_x >> SCALE_SHIFT);
         end
      end
   end

`ifdef SCANOUT_PAL_ROTATE_EN
   assign frame_wrap = y_changed && (vga_y == 12'd0);
`endif

endmodule

// File: rtl/vga_scanout_palette.sv
// Framebuffer scanout with double-buffered palette and aligned sync delay.
// Optional macro: SCANOUT_PAL_ROTATE_EN adds a per-frame palette index rotation.
module vga_scanout_palette
   import scanout_pkg::*;
#(
   parameter int WIDTH       = 1024,
   parameter int HEIGHT      = 768,
   parameter int SCALE_SHIFT = 0,
   parameter int DATA_BITS   = 4,
   parameter int COLOR_BITS  = 6,
   parameter int READ_DELAY  = 2,
   parameter int ADDR_BITS   = $clog2((WIDTH >> SCALE_SHIFT) * (HEIGHT >> SCALE_SHIFT))
) (
   input  logic                    clk_pixel,
   input  logic                    reset,
   input  logic [11:0]             vga_x,
   input  logic [11:0]             vga_y,
   input  logic                    video_active,
   input  logic                    hsync_in,
   input  logic                    vsync_in,
   vga_scanout_palette_if.master   fb,
   input  logic                    pal_we,
   input  logic [DATA_BITS-1:0]    pal_waddr,
   input  logic [3*COLOR_BITS-1:0] pal_wdata,
   input  logic                    pal_commit,
   output logic                    pal_pending,
   output logic [COLOR_BITS-1:0]   vga_r,
   output logic [COLOR_BITS-1:0]   vga_g,
   output logic [COLOR_BITS-1:0]   vga_b,
   output logic                    vga_hsync,
   output logic                    vga_vsync,
   output logic                    vga_active
`ifdef SCANOUT_PAL_ROTATE_EN
   ,
   input  logic [DATA_BITS-1:0]    pal_rot_step
`endif
);

   localparam int          L        = scanout_latency(READ_DELAY);
   localparam int          PAL_N    = 1 << DATA_BITS;
   localparam logic [11:0] HEIGHT_L = 12'(HEIGHT);

   typedef logic [3*COLOR_BITS-1:0] entry_t;

   function automatic entry_t default_entry(input int i);
      rgb_t e;
      e = DEFAULT_PALETTE[4'(i)];
      return {COLOR_BITS'(e.r), COLOR_BITS'(e.g), COLOR_BITS'(e.b)};
   endfunction

   entry_t                  shadow_pal [PAL_N];
   entry_t                  active_pal [PAL_N];
   logic                    pal_copy;
   logic [READ_DELAY-1:0]   in_range_pipe;
   logic [L-1:0][2:0]       sync_pipe;
   entry_t                  colour_q;
   logic [DATA_BITS-1:0]    idx;

`ifdef SCANOUT_PAL_ROTATE_EN
   logic                    frame_wrap;
   logic [DATA_BITS-1:0]    rot_offset;
`endif

   scanout_addr_gen #(
      .WIDTH       (WIDTH),
      .HEIGHT      (HEIGHT),
      .SCALE_SHIFT (SCALE_SHIFT),
      .ADDR_BITS   (ADDR_BITS)
   ) u_addr_gen (
      .clk_pixel    (clk_pixel),
      .reset        (reset),
      .fb           (fb),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .video_active (video_active)
`ifdef SCANOUT_PAL_ROTATE_EN
      ,
      .frame_wrap   (frame_wrap)
`endif
   );

   // Shadow-to-active copy only happens in vertical blank so a frame never
   // shows a half-updated palette.
   assign pal_copy = pal_pending && (vga_y >= HEIGHT_L) && !video_active;

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         pal_pending <= 1'b0;
         for (int i = 0; i < PAL_N; i++) begin
            shadow_pal[DATA_BITS'(i)] <= default_entry(i);
            active_pal[DATA_BITS'(i)] <= default_entry(i);
         end
      end else begin
         if (pal_we) begin
            shadow_pal[pal_waddr] <= pal_wdata;
         end
         if (pal_copy) begin
            active_pal <= shadow_pal;
         end
         if (pal_commit) begin
            pal_pending <= 1'b1;
         end else if (pal_copy) begin
            pal_pending <= 1'b0;
         end
      end
   end

`ifdef SCANOUT_PAL_ROTATE_EN
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         rot_offset <= '0;
      end else if (frame_wrap) begin
         rot_offset <= rot_offset + pal_rot_step;
      end
   end

   assign idx = fb.read_data + rot_offset;
`else
   assign idx = fb.read_data;
`endif

   // in_range rides along with the memory latency; syncs take the full
   // latency so they leave together with the colour they frame.
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         in_range_pipe <= '0;
         sync_pipe     <= '0;
         colour_q      <= '0;
      end else begin
         in_range_pipe <= READ_DELAY'({in_range_pipe, fb.read_en});
         sync_pipe     <= {sync_pipe[L-2:0], {hsync_in, vsync_in, video_active}};
         colour_q      <= (in_range_pipe[READ_DELAY-1] && sync_pipe[L-2][0])
                          ? active_pal[idx] : '0;
      end
   end

   assign {vga_r, vga_g, vga_b} = colour_q;
   assign vga_hsync  = sync_pipe[L-1][2];
   assign vga_vsync  = sync_pipe[L-1][1];
   assign vga_active = sync_pipe[L-1][0];

endmodule
